// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants and encodings for the Scale2X fetch path
package gpu_pkg;

    localparam int GPU_PW = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_E0 = 2'd0,
        SEL_E1 = 2'd1,
        SEL_E2 = 2'd2,
        SEL_E3 = 2'd3
    } opix_sel_t;

endpackage

// File: rtl/gpu_scale2x_fetch_if.sv
// rtl/gpu_scale2x_fetch_if.sv - neighbourhood stream from the fetch block to Scale2X
interface gpu_scale2x_fetch_if #(
    parameter int PW = gpu_pkg::GPU_PW
);
    logic [PW-1:0] ipix_B;
    logic [PW-1:0] ipix_D;
    logic [PW-1:0] ipix_E;
    logic [PW-1:0] ipix_F;
    logic [PW-1:0] ipix_H;
    logic [1:0]    opix_sel;
    logic          ipix_en;

    modport master (output ipix_B, ipix_D, ipix_E, ipix_F, ipix_H, opix_sel, ipix_en);
    modport slave  (input  ipix_B, ipix_D, ipix_E, ipix_F, ipix_H, opix_sel, ipix_en);
endinterface

// File: rtl/gpu_line_ram.sv
// rtl/gpu_line_ram.sv - one scanline bank, 1 write / 1 registered read port
module gpu_line_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int PW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);
    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // rdata only moves on re, so it can act as the F stage of the shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/gpu_scale2x_fetch.sv
// rtl/gpu_scale2x_fetch.sv - 4-line ring buffer feeding B/D/E/F/H neighbourhoods to Scale2X
module gpu_scale2x_fetch
    import gpu_pkg::*;
#(
    parameter int MAX_W = 256,
    parameter int AW    = 8,
    parameter int PW    = GPU_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src_sof,
    input  logic [PW-1:0] src_pix,
    input  logic          src_en,
    input  logic          src_eol,
    input  logic          dst_start,
    input  logic [8:0]    dst_line,
    input  logic          dst_odd,
    input  logic          dst_last,
    output logic          dst_busy,
    output logic          dst_done,
    gpu_scale2x_fetch_if.master pix,
    output logic          underrun
);
    logic [9:0]    wr_line, wl_eff;
    logic [AW-1:0] wr_x, wx_eff;
    logic          wr_full, wfull_eff, wr_ok;
    logic [AW:0]   line_w;

    // src_sof takes effect for the pixel arriving with it
    assign wl_eff    = src_sof ? '0 : wr_line;
    assign wx_eff    = src_sof ? '0 : wr_x;
    assign wfull_eff = src_sof ? 1'b0 : wr_full;
    assign wr_ok     = src_en && !wfull_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_line <= '0;
            wr_x    <= '0;
            wr_full <= 1'b0;
            line_w  <= '0;
        end else if (src_en && src_eol) begin
            wr_x    <= '0;
            wr_full <= 1'b0;
            wr_line <= wl_eff + 10'd1;
            line_w  <= wfull_eff ? (AW+1)'(MAX_W) : {1'b0, wx_eff} + (AW+1)'(1);
        end else if (src_en) begin
            wr_line <= wl_eff;
            if (wx_eff == AW'(MAX_W - 1)) begin
                wr_x    <= wx_eff;
                wr_full <= 1'b1;
            end else begin
                wr_x    <= wx_eff + AW'(1);
            end
        end else if (src_sof) begin
            wr_line <= '0;
            wr_x    <= '0;
            wr_full <= 1'b0;
        end
    end

    fetch_state_t  state;
    opix_sel_t     sel_q;
    logic          half, req_odd, ipix_en_q;
    logic [AW-1:0] x;
    logic [AW:0]   req_w, last_x;
    logic [1:0]    b_bank, e_bank, h_bank;
    logic [PW-1:0] d_pix, e_pix, b_pix, h_pix;
    logic [PW-1:0] bank_q [4];
    logic [PW-1:0] q_b, q_e, q_h;
    logic [3:0]    bank_we;
    logic          rd_en, x_is_last;
    logic [AW+1:0] rd_x;
    logic [AW-1:0] rd_addr;

    assign last_x    = req_w - (AW+1)'(1);
    assign x_is_last = ({1'b0, x} == last_x);
    assign q_b       = bank_q[b_bank];
    assign q_e       = bank_q[e_bank];
    assign q_h       = bank_q[h_bank];

    always_comb begin
        rd_en = 1'b0;
        rd_x  = '0;
        case (state)
            ST_PRIME: begin
                rd_en = 1'b1;
                rd_x  = (AW+2)'(half);
            end
            ST_RUN: begin
                rd_en = half && !x_is_last;
                rd_x  = (AW+2)'(x) + (AW+2)'(2);
            end
            default: ;
        endcase
    end
    assign rd_addr = (rd_x > (AW+2)'(last_x)) ? last_x[AW-1:0] : rd_x[AW-1:0];

    for (genvar i = 0; i < 4; i++) begin : g_bank
        assign bank_we[i] = wr_ok && (wl_eff[1:0] == 2'(i));
        gpu_line_ram #(.DEPTH(MAX_W), .AW(AW), .PW(PW)) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we[i]),
            .waddr (wx_eff),
            .wdata (src_pix),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (bank_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= SEL_E0;
            half      <= 1'b0;
            req_odd   <= 1'b0;
            ipix_en_q <= 1'b0;
            x         <= '0;
            req_w     <= '0;
            b_bank    <= '0;
            e_bank    <= '0;
            h_bank    <= '0;
            d_pix     <= '0;
            e_pix     <= '0;
            b_pix     <= '0;
            h_pix     <= '0;
            dst_busy  <= 1'b0;
            dst_done  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            dst_done <= 1'b0;
            if (src_sof) underrun <= 1'b0;
            case (state)
                ST_IDLE: if (dst_start) begin
                    req_odd  <= dst_odd;
                    req_w    <= line_w;
                    dst_busy <= 1'b1;
                    half     <= 1'b0;
                    e_bank   <= dst_line[1:0];
                    b_bank   <= (dst_line == 9'd0) ? dst_line[1:0] : dst_line[1:0] - 2'd1;
                    h_bank   <= dst_last ? dst_line[1:0] : dst_line[1:0] + 2'd1;
                    if (!dst_last && (({1'b0, dst_line} + 10'd1) >= wr_line)) underrun <= 1'b1;
                    if (line_w == '0) begin
                        state    <= ST_DONE;
                        dst_done <= 1'b1;
                    end else begin
                        state    <= ST_PRIME;
                    end
                end
                ST_PRIME: if (!half) begin
                    half <= 1'b1;
                end else begin
                    // column 0: left neighbour replicates the centre
                    state     <= ST_RUN;
                    half      <= 1'b0;
                    x         <= '0;
                    d_pix     <= q_e;
                    e_pix     <= q_e;
                    b_pix     <= q_b;
                    h_pix     <= q_h;
                    ipix_en_q <= 1'b1;
                    sel_q     <= req_odd ? SEL_E2 : SEL_E0;
                end
                ST_RUN: if (!half) begin
                    half  <= 1'b1;
                    sel_q <= req_odd ? SEL_E3 : SEL_E1;
                end else if (x_is_last) begin
                    state     <= ST_DONE;
                    half      <= 1'b0;
                    ipix_en_q <= 1'b0;
                    sel_q     <= SEL_E0;
                    dst_done  <= 1'b1;
                end else begin
                    x     <= x + AW'(1);
                    half  <= 1'b0;
                    sel_q <= req_odd ? SEL_E2 : SEL_E0;
                    d_pix <= e_pix;
                    e_pix <= q_e;
                    b_pix <= q_b;
                    h_pix <= q_h;
                end
                default: begin
                    state    <= ST_IDLE;
                    dst_busy <= 1'b0;
                end
            endcase
        end
    end

    assign pix.ipix_B   = b_pix;
    assign pix.ipix_D   = d_pix;
    assign pix.ipix_E   = e_pix;
    assign pix.ipix_F   = q_e;
    assign pix.ipix_H   = h_pix;
    assign pix.opix_sel = sel_q;
    assign pix.ipix_en  = ipix_en_q;
endmodule
